hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline hazard controller for the 5-stage core. Shadows the EX/MEM/WB destination-register state.
//   Drives the exec-stage operand forward selects, load-use stalls, branch/jump flushes and global freeze.
//   Sits beside the IF/ID/EX/MEM/WB stage modules; all stage enables and bubbles come from here.
// PARAMETERS
//   REG_AW   5   register address width
//   CNT_W    32  width of perf counters (HAZARD_PERF_EN only)
// PORTS
//   clk            in   1       core clock, all state on posedge
//   rst            in   1       asynchronous, active-high reset
//   id_valid       in   1       ID holds a real instruction
//   id_rs1_addr    in   REG_AW  decode-stage source 1
//   id_rs2_addr    in   REG_AW  decode-stage source 2
//   id_rd_addr     in   REG_AW  decode-stage destination
//   id_rd_we       in   1       decode-stage writes rd
//   id_res_src     in   2       00 ALU, 01 load, 10 next_pc
//   pc_src         in   1       taken branch/jump resolved in EX
//   mem_busy       in   1       data memory not ready; freeze whole pipe
//   forward_rs1    out  2       00 regfile, 01 MEM stage, 10 WB stage
//   forward_rs2    out  2       as forward_rs1
//   stall_if       out  1       hold PC
//   stall_id       out  1       hold IF/ID register
//   flush_id       out  1       IF/ID becomes bubble
//   flush_ex       out  1       ID/EX becomes bubble
//   freeze         out  1       hold ID/EX, EX/MEM, MEM/WB (= mem_busy)
//   stall_cnt      out  CNT_W   load-use stall cycles (HAZARD_PERF_EN only)
//   flush_cnt      out  CNT_W   flush events (HAZARD_PERF_EN only)
// BEHAVIOUR
//   - State: shadow regs per stage S in {EX,MEM,WB}: vld_S, rd_S, we_S, rs1_EX, rs2_EX, res_src_EX/MEM.
//   - Shadow reset: all vld=0, all fields 0.
//   - Shadow advance on posedge unless freeze. EX<=ID fields when id_valid & !stall_id & !flush_ex, else bubble (vld=0). MEM<=EX. WB<=MEM.
//   - Output reset: every output 0.
//   - Outputs are combinational from shadow + inputs, so decisions take effect in the same cycle.
//   - Forwarding (per rsN_EX): rsN_EX!=0 & vld_MEM & we_MEM & rd_MEM==rsN_EX & res_src_MEM!=01 -> 01.
//     Otherwise, if vld_WB & we_WB & rd_WB==rsN_EX -> 10. Otherwise 00. MEM beats WB; x0 never forwarded.
//   - Load-use: vld_EX & we_EX & res_src_EX==01 & rd_EX!=0 & id_valid & (rd_EX==id_rs1|rd_EX==id_rs2).
//     Response: stall_if=stall_id=flush_ex=1 for exactly one cycle. Next cycle the load is in MEM; it resolves via WB forward the cycle after.
//   - Load in MEM with a dependent in EX cannot occur; verify with an assertion, not logic.
//   - pc_src=1: flush_id=flush_ex=1, stall_*=0 in that cycle. Flush beats load-use stall.
//   - freeze=mem_busy: shadow holds; stall_if=stall_id=1; flush_* held 0.
//     A pending pc_src or load-use is re-evaluated after release (inputs held by frozen stages).
//   - WB->ID same-cycle hazard is covered by the register file's write-first read; not handled here.
//   - Reset mid-operation: shadow cleared immediately (async); first post-reset cycle forwards 00, no stall.
// CONFIGURATION
//   HAZARD_PERF_EN defined:
//     stall_cnt +1 per cycle with load-use stall asserted (not freeze).
//     flush_cnt +1 per cycle with pc_src & !freeze.
//     Both counters are 0 on reset and wrap at 2^CNT_W.
//   Undefined: counters and ports absent, no other change.
// STRUCTURE
//   Shared constants header:
//     FWD_REG/FWD_MEM/FWD_WB (2'b00/01/10)
//     RES_ALU/RES_LOAD/RES_PC (2'b00/01/10)
//   Sub-module hazard_fwd_sel: one instance per source operand.
//     Inputs: rs address, MEM/WB shadow fields. Output: 2-bit select.
//   Shadow pipeline and stall/flush logic stay in hazard_ctrl.
// TESTING
//   1. add x5 in EX, next add uses x5 -> cycle after: forward_rs1=01. Cycle after that (no new writer): forward_rs1=10.
//   2. lw x6 in EX, ID reads rs2=x6 -> stall_if=stall_id=flush_ex=1 for 1 cycle. Then forward_rs2=10 when dependent reaches EX.
//   3. Writes to x0 in MEM and WB, EX reads x0 -> forward_rs1=forward_rs2=00.
//   4. pc_src=1 same cycle as load-use condition -> flush_id=flush_ex=1, stall_if=0. Next cycle EX shadow vld=0.
//   5. mem_busy high 3 cycles during forward 01 -> forward held, freeze=1, no flush. Release resumes identically.
//   6. rst pulse mid-stream with x7 in MEM -> all outputs 0. Post-reset read of x7 -> forward 00.
//      With HAZARD_PERF_EN: counters 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: forward selects and result sources.
// HAZARD_PERF_EN (optional) adds load-use stall and flush event counters.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC   = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/exec-side request signals and hazard control responses.
// Counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
`ifdef HAZARD_PERF_EN
    , parameter int CNT_W = 32
`endif
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1_addr;
    logic [REG_AW-1:0] id_rs2_addr;
    logic [REG_AW-1:0] id_rd_addr;
    logic              id_rd_we;
    logic [1:0]        id_res_src;
    logic              pc_src;
    logic              mem_busy;
    logic [1:0]        forward_rs1;
    logic [1:0]        forward_rs2;
    logic              stall_if;
    logic              stall_id;
    logic              flush_id;
    logic              flush_ex;
    logic              freeze;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
        output id_rd_we, id_res_src, pc_src, mem_busy,
`ifdef HAZARD_PERF_EN
        input  stall_cnt, flush_cnt,
`endif
        input  forward_rs1, forward_rs2, stall_if, stall_id,
        input  flush_id, flush_ex, freeze
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
        input  id_rd_we, id_res_src, pc_src, mem_busy,
`ifdef HAZARD_PERF_EN
        output stall_cnt, flush_cnt,
`endif
        output forward_rs1, forward_rs2, stall_if, stall_id,
        output flush_id, flush_ex, freeze
    );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Operand forward select for one EX source register; MEM beats WB, x0 never forwards.
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic              i_vld_mem,
    input  logic              i_we_mem,
    input  logic [REG_AW-1:0] i_rd_mem,
    input  logic [1:0]        i_res_mem,
    input  logic              i_vld_wb,
    input  logic              i_we_wb,
    input  logic [REG_AW-1:0] i_rd_wb,
    output logic [1:0]        o_sel
);

    logic w_nz;
    logic w_hit_mem;
    logic w_hit_wb;

    // A load still in MEM has no data yet, so it can only forward from WB.
    assign w_nz      = (i_rs != '0);
    assign w_hit_mem = w_nz & i_vld_mem & i_we_mem & (i_rd_mem == i_rs)
                     & (i_res_mem != RES_LOAD);
    assign w_hit_wb  = w_nz & i_vld_wb & i_we_wb & (i_rd_wb == i_rs);

    always_comb begin
        o_sel = FWD_REG;
        if (w_hit_mem)
            o_sel = FWD_MEM;
        else if (w_hit_wb)
            o_sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: forwarding, load-use stall, flush, freeze.
// HAZARD_PERF_EN adds stall_cnt/flush_cnt event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
`ifdef HAZARD_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    logic              r_ex_vld, r_ex_we;
    logic [REG_AW-1:0] r_ex_rd, r_ex_rs1, r_ex_rs2;
    logic [1:0]        r_ex_res;
    logic              r_mem_vld, r_mem_we;
    logic [REG_AW-1:0] r_mem_rd;
    logic [1:0]        r_mem_res;
    logic              r_wb_vld, r_wb_we;
    logic [REG_AW-1:0] r_wb_rd;

    logic       w_load_use;
    logic       w_stall;
    logic       w_flush_id;
    logic       w_flush_ex;
    logic       w_adv_id;
    logic [1:0] w_fwd1;
    logic [1:0] w_fwd2;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd1 (
        .i_rs(r_ex_rs1), .i_vld_mem(r_mem_vld), .i_we_mem(r_mem_we),
        .i_rd_mem(r_mem_rd), .i_res_mem(r_mem_res), .i_vld_wb(r_wb_vld),
        .i_we_wb(r_wb_we), .i_rd_wb(r_wb_rd), .o_sel(w_fwd1)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd2 (
        .i_rs(r_ex_rs2), .i_vld_mem(r_mem_vld), .i_we_mem(r_mem_we),
        .i_rd_mem(r_mem_rd), .i_res_mem(r_mem_res), .i_vld_wb(r_wb_vld),
        .i_we_wb(r_wb_we), .i_rd_wb(r_wb_rd), .o_sel(w_fwd2)
    );

    assign w_load_use = r_ex_vld & r_ex_we & (r_ex_res == RES_LOAD)
                      & (r_ex_rd != '0) & hz.id_valid
                      & ((r_ex_rd == hz.id_rs1_addr)
                       | (r_ex_rd == hz.id_rs2_addr));

    // Freeze dominates, then a taken branch, then the load-use bubble.
    always_comb begin
        w_stall    = 1'b0;
        w_flush_id = 1'b0;
        w_flush_ex = 1'b0;
        if (hz.mem_busy) begin
            w_stall = 1'b1;
        end else if (hz.pc_src) begin
            w_flush_id = 1'b1;
            w_flush_ex = 1'b1;
        end else if (w_load_use) begin
            w_stall    = 1'b1;
            w_flush_ex = 1'b1;
        end
    end

    assign w_adv_id = hz.id_valid & ~w_stall & ~w_flush_ex;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_vld  <= 1'b0;
            r_ex_we   <= 1'b0;
            r_ex_rd   <= '0;
            r_ex_rs1  <= '0;
            r_ex_rs2  <= '0;
            r_ex_res  <= '0;
            r_mem_vld <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_rd  <= '0;
            r_mem_res <= '0;
            r_wb_vld  <= 1'b0;
            r_wb_we   <= 1'b0;
            r_wb_rd   <= '0;
        end else if (!hz.mem_busy) begin
            r_ex_vld  <= w_adv_id;
            r_ex_we   <= w_adv_id & hz.id_rd_we;
            r_ex_rd   <= w_adv_id ? hz.id_rd_addr  : '0;
            r_ex_rs1  <= w_adv_id ? hz.id_rs1_addr : '0;
            r_ex_rs2  <= w_adv_id ? hz.id_rs2_addr : '0;
            r_ex_res  <= w_adv_id ? hz.id_res_src  : '0;
            r_mem_vld <= r_ex_vld;
            r_mem_we  <= r_ex_we;
            r_mem_rd  <= r_ex_rd;
            r_mem_res <= r_ex_res;
            r_wb_vld  <= r_mem_vld;
            r_wb_we   <= r_mem_we;
            r_wb_rd   <= r_mem_rd;
        end
    end

    assign hz.forward_rs1 = rst ? FWD_REG : w_fwd1;
    assign hz.forward_rs2 = rst ? FWD_REG : w_fwd2;
    assign hz.stall_if    = ~rst & w_stall;
    assign hz.stall_id    = ~rst & w_stall;
    assign hz.flush_id    = ~rst & w_flush_id;
    assign hz.flush_ex    = ~rst & w_flush_ex;
    assign hz.freeze      = ~rst & hz.mem_busy;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!hz.mem_busy) begin
            if (w_load_use & ~hz.pc_src)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (hz.pc_src)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;
`endif

    // The load-use bubble guarantees a load in MEM never feeds the EX op.
    a_no_mem_load_dep: assert property (@(posedge clk) disable iff (rst)
        !(r_mem_vld & r_mem_we & (r_mem_res == RES_LOAD) & (r_mem_rd != '0)
          & r_ex_vld & ((r_ex_rs1 == r_mem_rd) | (r_ex_rs2 == r_mem_rd))));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against an in-order instruction-slot model.
// Define HAZARD_PERF_EN to also check the event counters.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5)) hz ();

    hazard_ctrl #(.REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    typedef struct {
        bit v;
        int rd;
        bit we;
        int rs1;
        int rs2;
        int res;
    } ins_t;

    // slot 0 = EX, 1 = MEM, 2 = WB
    ins_t   pipe[3];
    longint m_stall_cnt;
    longint m_flush_cnt;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_fwd(int rs);
        if (rs == 0) return 0;
        if (pipe[1].v && pipe[1].we && pipe[1].rd == rs && pipe[1].res != 1)
            return 1;
        if (pipe[2].v && pipe[2].we && pipe[2].rd == rs)
            return 2;
        return 0;
    endfunction

    function automatic void m_clear();
        ins_t b;
        b = '{v: 0, rd: 0, we: 0, rs1: 0, rs2: 0, res: 0};
        for (int i = 0; i < 3; i++) pipe[i] = b;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endfunction

    task automatic step(bit v, int rs1, int rs2, int rd, bit we, int res,
                        bit pc, bit busy);
        bit   lu;
        bit   e_stall, e_fid, e_fex;
        ins_t id;
        @(negedge clk);
        hz.id_valid    = v;
        hz.id_rs1_addr = 5'(rs1);
        hz.id_rs2_addr = 5'(rs2);
        hz.id_rd_addr  = 5'(rd);
        hz.id_rd_we    = we;
        hz.id_res_src  = 2'(res);
        hz.pc_src      = pc;
        hz.mem_busy    = busy;
        #1;
        lu = pipe[0].v && pipe[0].we && pipe[0].res == 1 && pipe[0].rd != 0
             && v && (pipe[0].rd == rs1 || pipe[0].rd == rs2);
        e_stall = busy || (!pc && lu);
        e_fid   = !busy && pc;
        e_fex   = !busy && (pc || lu);
        check("fwd1", 64'(hz.forward_rs1), 64'(m_fwd(pipe[0].rs1)));
        check("fwd2", 64'(hz.forward_rs2), 64'(m_fwd(pipe[0].rs2)));
        check("stall_if", 64'(hz.stall_if), 64'(e_stall));
        check("stall_id", 64'(hz.stall_id), 64'(e_stall));
        check("flush_id", 64'(hz.flush_id), 64'(e_fid));
        check("flush_ex", 64'(hz.flush_ex), 64'(e_fex));
        check("freeze", 64'(hz.freeze), 64'(busy));
`ifdef HAZARD_PERF_EN
        check("stall_cnt", 64'(hz.stall_cnt), 64'(m_stall_cnt & 32'hffffffff));
        check("flush_cnt", 64'(hz.flush_cnt), 64'(m_flush_cnt & 32'hffffffff));
`endif
        if (!busy) begin
            if (lu && !pc) m_stall_cnt++;
            if (pc) m_flush_cnt++;
            id = '{v: v, rd: rd, we: we, rs1: rs1, rs2: rs2, res: res};
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (v && !pc && !lu)
                pipe[0] = id;
            else
                pipe[0] = '{v: 0, rd: 0, we: 0, rs1: 0, rs2: 0, res: 0};
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_clear();
        check("rst_fwd1", 64'(hz.forward_rs1), 64'd0);
        check("rst_fwd2", 64'(hz.forward_rs2), 64'd0);
        check("rst_stall", 64'({hz.stall_if, hz.stall_id}), 64'd0);
        check("rst_flush", 64'({hz.flush_id, hz.flush_ex}), 64'd0);
        check("rst_freeze", 64'(hz.freeze), 64'd0);
`ifdef HAZARD_PERF_EN
        check("rst_cnt", 64'({hz.stall_cnt, hz.flush_cnt}), 64'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        hz.id_valid    = 1'b0;
        hz.id_rs1_addr = '0;
        hz.id_rs2_addr = '0;
        hz.id_rd_addr  = '0;
        hz.id_rd_we    = 1'b0;
        hz.id_res_src  = '0;
        hz.pc_src      = 1'b1;
        hz.mem_busy    = 1'b1;
        m_clear();
        do_reset();

        // add x5 then two readers of x5: MEM forward, then WB forward
        step(1, 1, 2, 5, 1, 0, 0, 0);
        step(1, 5, 3, 8, 1, 0, 0, 0);
        step(1, 5, 0, 9, 0, 0, 0, 0);
        check("t1_mem", 64'(hz.forward_rs1), 64'd1);
        idle();
        check("t1_wb", 64'(hz.forward_rs1), 64'd2);
        idle(); idle();

        // lw x6 then a reader of rs2=x6: one-cycle stall, then WB forward
        step(1, 1, 0, 6, 1, 1, 0, 0);
        step(1, 2, 6, 7, 1, 0, 0, 0);
        check("t2_stall", 64'({hz.stall_if, hz.stall_id, hz.flush_ex}), 64'h7);
        step(1, 2, 6, 7, 1, 0, 0, 0);
        check("t2_once", 64'(hz.stall_if), 64'd0);
        idle();
        check("t2_wb", 64'(hz.forward_rs2), 64'd2);
        idle(); idle();

        // writes to x0 never forward
        step(1, 1, 1, 0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 4, 1, 0, 0, 0);
        idle();
        check("t3_x0", 64'({hz.forward_rs1, hz.forward_rs2}), 64'd0);
        idle(); idle();

        // branch flush beats load-use
        step(1, 1, 0, 6, 1, 1, 0, 0);
        step(1, 6, 0, 7, 1, 0, 1, 0);
        check("t4_flush", 64'({hz.flush_id, hz.flush_ex, hz.stall_if}), 64'h6);

        // freeze holds a MEM forward for 3 cycles
        step(1, 1, 2, 5, 1, 0, 0, 0);
        step(1, 5, 0, 8, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1);
            check("t5_hold", 64'({hz.forward_rs1, hz.freeze, hz.flush_ex}),
                  64'h6);
        end
        idle();
        check("t5_resume", 64'(hz.forward_rs1), 64'd1);

        // reset with x7 in MEM, then read x7
        step(1, 0, 0, 7, 1, 0, 0, 0);
        idle();
        do_reset();
        step(1, 7, 7, 1, 1, 0, 0, 0);
        idle();
        check("t6_post", 64'({hz.forward_rs1, hz.forward_rs2}), 64'd0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0)
                do_reset();
            else
                step($urandom_range(0, 3) != 0,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                     int'($urandom_range(0, 2)),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
